// File: rtl/blockade_pkg.sv
// Shared constants, state types and byte-building helpers for the Blockade input front end.
package blockade_pkg;

    localparam logic [1:0] GAME_BLOCKADE = 2'd0;
    localparam logic [1:0] GAME_COMOTION = 2'd1;
    localparam logic [1:0] GAME_HUSTLE   = 2'd2;
    localparam logic [1:0] GAME_BLASTO   = 2'd3;

    typedef enum logic [1:0] {COIN_IDLE, COIN_PULSE, COIN_WAIT_REL} coin_state_t;
    typedef enum logic       {SET_RUN, SET_SETTLE} settle_state_t;

    // DIP field base indices
    localparam int DIP_LIVES = 0;
    localparam int DIP_TIME  = 2;
    localparam int DIP_DEMO  = 3;
    localparam int DIP_COIN  = 4;
    localparam int DIP_EXT   = 8;

    localparam int BTN_COIN   = 0;
    localparam int BTN_START1 = 1;
    localparam int BTN_START2 = 2;
    localparam int BTN_FIRE1  = 3;
    localparam int BTN_FIRE2  = 4;
    localparam int BTN_BOOM   = 5;

    typedef struct packed {
        logic up;
        logic down;
        logic left;
        logic right;
    } joy_t;

    function automatic logic [3:0] ldru(input joy_t j);
        return {j.left, j.down, j.right, j.up};
    endfunction

    function automatic logic [3:0] uldr(input joy_t j);
        return {j.up, j.left, j.down, j.right};
    endfunction

    // Frame counters saturate instead of wrapping.
    function automatic logic [3:0] sat_inc(input logic [3:0] v);
        return (v == 4'hF) ? v : v + 4'd1;
    endfunction

endpackage

// File: rtl/input_debounce.sv
// Per-bit debouncer: input register, then a bit flips after DEBOUNCE_CYCLES consecutive disagreements.
module input_debounce #(
    parameter int WIDTH           = 6,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic             clk_sys,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] raw,
    output logic [WIDTH-1:0] deb
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic [WIDTH-1:0] raw_q;

    always_ff @(posedge clk_sys) begin
        if (!reset_n) raw_q <= '0;
        else          raw_q <= raw;
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        logic [CW-1:0] cnt;
        logic          deb_r;

        always_ff @(posedge clk_sys) begin
            if (!reset_n) begin
                cnt   <= '0;
                deb_r <= 1'b0;
            end else if (raw_q[i] == deb_r) begin
                cnt <= '0;
            end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
                cnt   <= '0;
                deb_r <= raw_q[i];
            end else begin
                cnt <= cnt + 1'b1;
            end
        end

        assign deb[i] = deb_r;
    end
endmodule

// File: rtl/blockade_input_ctrl.sv
// Registered input front end: debounce, frame tick, coin pulse shaping, mode-change settle
// and per-mode assembly of the active-low IN_1/IN_2/IN_4 bytes.
module blockade_input_ctrl
    import blockade_pkg::*;
#(
    parameter int NUM_PLAYERS     = 4,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int COIN_FRAMES     = 3,
    parameter int SETTLE_FRAMES   = 2
) (
    input  logic                     clk_sys,
    input  logic                     reset_n,
    input  logic [4*NUM_PLAYERS-1:0] joy,
    input  logic [5:0]               btn,
    input  logic [15:0]              dips,
    input  logic [1:0]               game_mode,
    input  logic                     vblank,
    output logic [7:0]               in_1,
    output logic [7:0]               in_2,
    output logic [7:0]               in_4,
    output logic                     coin
);
    logic [4*NUM_PLAYERS-1:0] joy_deb;
    logic [5:0]               btn_deb;

    input_debounce #(.WIDTH(4*NUM_PLAYERS), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_joy_deb (
        .clk_sys (clk_sys),
        .reset_n (reset_n),
        .raw     (joy),
        .deb     (joy_deb)
    );

    input_debounce #(.WIDTH(6), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn_deb (
        .clk_sys (clk_sys),
        .reset_n (reset_n),
        .raw     (btn),
        .deb     (btn_deb)
    );

    logic vblank_q, tick;

    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            vblank_q <= 1'b0;
            tick     <= 1'b0;
        end else begin
            vblank_q <= vblank;
            tick     <= vblank & ~vblank_q;
        end
    end

    settle_state_t settle_st;
    logic [3:0]    settle_cnt;
    logic [1:0]    mode_q;
    logic          mode_chg;

    assign mode_chg = (game_mode != mode_q);

    // A mode change beats a coincident tick: the settle count restarts from zero.
    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            settle_st  <= SET_SETTLE;
            settle_cnt <= 4'd0;
            mode_q     <= game_mode;
        end else begin
            mode_q <= game_mode;
            if (mode_chg) begin
                settle_st  <= SET_SETTLE;
                settle_cnt <= 4'd0;
            end else if (settle_st == SET_SETTLE && tick) begin
                settle_cnt <= sat_inc(settle_cnt);
                if (sat_inc(settle_cnt) >= 4'(SETTLE_FRAMES)) settle_st <= SET_RUN;
            end
        end
    end

    coin_state_t coin_st;
    logic [3:0]  coin_cnt;
    logic        coin_prev, coin_deb, coin_forced;

    assign coin_deb    = btn_deb[BTN_COIN];
    assign coin_forced = mode_chg || (settle_st == SET_SETTLE);

    // While settling the FSM tracks the held state, so a coin held across the
    // end of settle can never look like a fresh press.
    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            coin_st   <= COIN_IDLE;
            coin_cnt  <= 4'd0;
            coin_prev <= 1'b0;
        end else begin
            coin_prev <= coin_deb;
            if (coin_forced) begin
                coin_st <= coin_deb ? COIN_WAIT_REL : COIN_IDLE;
            end else begin
                case (coin_st)
                    COIN_IDLE: if (coin_deb && !coin_prev) begin
                        coin_st  <= COIN_PULSE;
                        coin_cnt <= 4'd0;
                    end
                    COIN_PULSE: if (tick) begin
                        coin_cnt <= sat_inc(coin_cnt);
                        if (sat_inc(coin_cnt) >= 4'(COIN_FRAMES)) coin_st <= COIN_WAIT_REL;
                    end
                    COIN_WAIT_REL: if (!coin_deb) coin_st <= COIN_IDLE;
                    default: coin_st <= COIN_IDLE;
                endcase
            end
        end
    end

    assign coin = (coin_st == COIN_PULSE);

    // Masking also covers the cycle the change is first seen, before settle_st flips.
    logic run;
    assign run = (settle_st == SET_RUN) && !mode_chg;

    logic start1, start2, fire1, fire2, boom;
    assign start1 = run & btn_deb[BTN_START1];
    assign start2 = run & btn_deb[BTN_START2];
    assign fire1  = run & btn_deb[BTN_FIRE1];
    assign fire2  = run & btn_deb[BTN_FIRE2];
    assign boom   = run & btn_deb[BTN_BOOM];

    joy_t [3:0] pj;
    for (genvar p = 0; p < 4; p++) begin : g_player
        localparam int SRC = (p < NUM_PLAYERS) ? p : p - 2;
        assign pj[p] = run ? joy_t'(joy_deb[4*SRC +: 4]) : joy_t'(4'b0000);
    end

    logic dips_unused;
    assign dips_unused = ^dips[7:4];

    logic [7:0] n1, n2, n4;

    always_comb begin
        n1 = 8'hFF;
        n2 = 8'hFF;
        n4 = 8'hFF;
        case (game_mode)
            GAME_BLOCKADE: begin
                n1 = ~{coin, dips[2:0], 1'b0, boom, 2'b00};
                n2 = ~{ldru(pj[0]), ldru(pj[1])};
            end
            GAME_COMOTION: begin
                n1 = ~{coin, 2'b00, start1 | start2, dips[0], boom, 2'b00};
                n2 = ~{ldru(pj[1]), ldru(pj[0])};
                n4 = ~{ldru(pj[3]), ldru(pj[2])};
            end
            GAME_HUSTLE: begin
                n1 = ~{coin, 2'b00, start2, start1, dips[2], dips[1:0]};
                n2 = ~{ldru(pj[0]), ldru(pj[1])};
                n4 = dips[DIP_EXT +: 8];
            end
            default: begin
                n1 = ~{coin, 3'b000, dips[3], dips[2], dips[1:0]};
                n2 = ~{fire1, start2, start1, 4'b0000, fire2};
                n4 = ~{uldr(pj[0]), uldr(pj[1])};
            end
        endcase
    end

    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            in_1 <= 8'hFF;
            in_2 <= 8'hFF;
            in_4 <= 8'hFF;
        end else begin
            in_1 <= n1;
            in_2 <= n2;
            in_4 <= n4;
        end
    end
endmodule

// File: tb/tb_blockade_input_ctrl.sv
// Directed bench for blockade_input_ctrl: a 4-player and a 2-player instance share stimulus.
module tb_blockade_input_ctrl;
    localparam int P = 20;

    logic        clk_sys = 1'b0;
    logic        reset_n;
    logic [15:0] joy;
    logic [5:0]  btn;
    logic [15:0] dips;
    logic [1:0]  game_mode;
    logic        vblank;
    logic [7:0]  a1, a2, a4, b1, b2, b4;
    logic        acoin, bcoin;

    int total = 0;
    int bad   = 0;

    always #5 clk_sys = ~clk_sys;

    blockade_input_ctrl #(.NUM_PLAYERS(4)) dut4 (
        .clk_sys(clk_sys), .reset_n(reset_n), .joy(joy), .btn(btn), .dips(dips),
        .game_mode(game_mode), .vblank(vblank), .in_1(a1), .in_2(a2), .in_4(a4), .coin(acoin)
    );

    blockade_input_ctrl #(.NUM_PLAYERS(2)) dut2 (
        .clk_sys(clk_sys), .reset_n(reset_n), .joy(joy[7:0]), .btn(btn), .dips(dips),
        .game_mode(game_mode), .vblank(vblank), .in_1(b1), .in_2(b2), .in_4(b4), .coin(bcoin)
    );

    // Free-running frame: vblank high 4 of every P cycles, changed on the falling edge.
    int fcnt = 0;
    initial begin
        vblank = 1'b0;
        forever begin
            @(negedge clk_sys);
            fcnt   = (fcnt + 1) % P;
            vblank = (fcnt < 4);
        end
    end

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk_sys);
            #1;
        end
    endtask

    task automatic wait_vrise();
        logic vp, got;
        vp  = vblank;
        got = 1'b0;
        for (int k = 0; k < 3*P; k++) begin
            cyc(1);
            if (vblank && !vp) begin
                got = 1'b1;
                break;
            end
            vp = vblank;
        end
        chk("vblank align", {7'd0, got}, 8'd1);
    endtask

    typedef struct {
        logic [1:0]  mode;
        logic [15:0] joy;
        logic [5:0]  btn;
        logic [15:0] dips;
        logic [7:0]  e1, e2, e4, e4b;
    } vec_t;

    vec_t tbl [8];

    initial begin
        int n, hi, lo7, pulses, rises, seen;
        logic got, cp, vp;

        tbl[0] = '{2'd0, 16'h0000, 6'h00, 16'h0003, 8'hCF, 8'hFF, 8'hFF, 8'hFF};
        tbl[1] = '{2'd0, 16'h0008, 6'h20, 16'h0003, 8'hCB, 8'hEF, 8'hFF, 8'hFF};
        tbl[2] = '{2'd0, 16'h0021, 6'h00, 16'h0007, 8'h8F, 8'hD7, 8'hFF, 8'hFF};
        tbl[3] = '{2'd1, 16'h0200, 6'h04, 16'h0001, 8'hE7, 8'hFF, 8'hF7, 8'hFF};
        tbl[4] = '{2'd1, 16'h8002, 6'h00, 16'h0000, 8'hFF, 8'hF7, 8'hEF, 8'hF7};
        tbl[5] = '{2'd2, 16'h0040, 6'h02, 16'hD105, 8'hF2, 8'hFB, 8'hD1, 8'hD1};
        tbl[6] = '{2'd3, 16'h0029, 6'h18, 16'h000F, 8'hF0, 8'h7E, 8'h6B, 8'h6B};
        tbl[7] = '{2'd3, 16'h0000, 6'h06, 16'h0000, 8'hFF, 8'h9F, 8'hFF, 8'hFF};

        // Reset state, then DIPs visible during settle and no coin activity.
        reset_n = 1'b0; joy = '0; btn = '0; dips = 16'h0003; game_mode = 2'd0;
        cyc(3);
        chk("reset in_1", a1, 8'hFF);
        chk("reset in_2", a2, 8'hFF);
        chk("reset in_4", a4, 8'hFF);
        chk("reset coin", {7'd0, acoin}, 8'd0);
        chk("reset in_1 np2", b1, 8'hFF);
        reset_n = 1'b1;
        cyc(2);
        chk("settle dips in_1", a1, 8'hCF);
        seen = 0;
        for (int k = 0; k < 3*P; k++) begin
            cyc(1);
            if (acoin) seen++;
        end
        chk("idle coin", seen[7:0], 8'd0);
        chk("idle in_1", a1, 8'hCF);
        chk("idle in_2", a2, 8'hFF);
        chk("idle in_4", a4, 8'hFF);

        for (int i = 0; i < 8; i++) begin
            game_mode = tbl[i].mode; joy = tbl[i].joy; btn = tbl[i].btn; dips = tbl[i].dips;
            cyc(4*P);
            chk($sformatf("vec%0d in_1", i), a1, tbl[i].e1);
            chk($sformatf("vec%0d in_2", i), a2, tbl[i].e2);
            chk($sformatf("vec%0d in_4", i), a4, tbl[i].e4);
            chk($sformatf("vec%0d np2 in_2", i), b2, tbl[i].e2);
            chk($sformatf("vec%0d np2 in_4", i), b4, tbl[i].e4b);
        end

        // Debounce: 3-cycle glitch is filtered, a held press lands DEBOUNCE_CYCLES+2 later.
        game_mode = 2'd0; joy = '0; btn = '0; dips = 16'h0003;
        cyc(4*P);
        joy = 16'h0008;
        cyc(3);
        joy = '0;
        seen = 0;
        for (int k = 0; k < P; k++) begin
            cyc(1);
            if (a2 != 8'hFF) seen++;
        end
        chk("glitch filtered", seen[7:0], 8'd0);
        joy = 16'h0008;
        n = 0; got = 1'b0;
        for (int k = 0; k < 30; k++) begin
            cyc(1);
            n++;
            if (!a2[4]) begin got = 1'b1; break; end
        end
        chk("debounce latency", n[7:0], 8'd6);
        chk("debounce seen", {7'd0, got}, 8'd1);
        chk("p1 up in_2", a2, 8'hEF);
        joy = '0;
        cyc(10);

        // Hustle DIP bytes, then switch to Blasto with P1 held: released for two ticks.
        game_mode = 2'd2; dips = 16'hD105; joy = 16'h0008;
        cyc(4*P);
        chk("hustle in_4", a4, 8'hD1);
        chk("hustle in_1 low", {5'd0, a1[2:0]}, 8'h02);
        wait_vrise();
        cyc(10);
        game_mode = 2'd3;
        vp = vblank; rises = 0; got = 1'b0;
        for (int k = 0; k < 6*P; k++) begin
            cyc(1);
            if (vblank && !vp) rises++;
            vp = vblank;
            if (a4 != 8'hFF) begin got = 1'b1; break; end
        end
        chk("blasto settle ticks", rises[7:0], 8'd2);
        chk("blasto released", {7'd0, got}, 8'd1);
        chk("blasto p1 in_4", a4, 8'h7F);

        // Coin held 50 frames in Blasto: exactly one pulse of COIN_FRAMES ticks.
        joy = '0; dips = '0;
        cyc(10);
        btn = 6'h01;
        hi = 0; lo7 = 0; pulses = 0; cp = 1'b0;
        for (int k = 0; k < 50*P; k++) begin
            cyc(1);
            if (acoin) hi++;
            if (acoin && !cp) pulses++;
            cp = acoin;
            if (!a1[7]) lo7++;
        end
        btn = '0;
        cyc(10);
        chk("coin pulses", pulses[7:0], 8'd1);
        chk("coin length", {7'd0, (hi > 2*P) && (hi <= 3*P)}, 8'd1);
        chk("in_1 coin bit", lo7[7:0], hi[7:0]);

        // Mode change mid-pulse drops coin on the next cycle.
        btn = 6'h01; got = 1'b0;
        for (int k = 0; k < 20; k++) begin
            cyc(1);
            if (acoin) begin got = 1'b1; break; end
        end
        chk("coin start (mode)", {7'd0, got}, 8'd1);
        game_mode = 2'd0;
        cyc(1);
        chk("coin abort mode", {7'd0, acoin}, 8'd0);
        btn = '0;
        cyc(4*P);

        // Reset mid-pulse.
        btn = 6'h01; got = 1'b0;
        for (int k = 0; k < 20; k++) begin
            cyc(1);
            if (acoin) begin got = 1'b1; break; end
        end
        chk("coin start (reset)", {7'd0, got}, 8'd1);
        reset_n = 1'b0;
        cyc(1);
        chk("coin abort reset", {7'd0, acoin}, 8'd0);
        btn = '0;
        cyc(2);
        reset_n = 1'b1;
        cyc(4*P);

        // Mode change on a tick cycle plus a coin press inside the settle window.
        joy = 16'h0002;
        cyc(4*P);
        chk("blockade p1 left", a2, 8'h7F);
        wait_vrise();
        game_mode = 2'd1;
        vp = vblank; rises = 0; seen = 0; got = 1'b0;
        for (int k = 0; k < 6*P; k++) begin
            if (k == 3)  btn = 6'h01;
            if (k == 15) btn = 6'h00;
            cyc(1);
            if (acoin) seen++;
            if (vblank && !vp) rises++;
            vp = vblank;
            if (a2 != 8'hFF) begin got = 1'b1; break; end
        end
        chk("tick+mode settle ticks", rises[7:0], 8'd2);
        chk("settle coin ignored", seen[7:0], 8'd0);
        chk("comotion p1 left", a2, 8'hF7);
        chk("comotion settled", {7'd0, got}, 8'd1);
        cyc(10);
        btn = 6'h01; got = 1'b0;
        for (int k = 0; k < 20; k++) begin
            cyc(1);
            if (acoin) begin got = 1'b1; break; end
        end
        chk("coin idle after settle", {7'd0, got}, 8'd1);
        btn = '0;
        cyc(10);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
